// File: rtl/comm_pkg.sv
// Shared definitions for the coprocessor serial link (transmit and receive paths).
//   FRAME_W / FRAME_BYTES : size of one frame in bits and in UART bytes
//   tx_state_t            : transmit frame state machine encoding
//   clks_per_bit()        : clock cycles per bit period, shared with the receiver
//   even_parity()         : parity bit used when UART_TX_PARITY_EN is defined
package comm_pkg;

    localparam int FRAME_W     = 136;
    localparam int FRAME_BYTES = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/uart_frame_tx_baud_tick.sv
// baud_tick: bit-period timer for the frame transmitter.
//   clk, resetn : system clock, asynchronous active-low reset
//   clear       : restart the bit period (frame acceptance)
//   tick        : one-cycle pulse in the last cycle of every bit period
// The counter runs 0..CLKS_PER_BIT-1 and wraps; tick is registered and is
// high exactly while the count sits at CLKS_PER_BIT-1.
module baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Bit-period counter; tick is raised one cycle ahead so it lines up with the wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends one 136-bit frame as 17 UART bytes, LSB byte first,
// each byte LSB bit first, 8N1 framing.
//   clk, resetn  : system clock, asynchronous active-low reset
//   start        : frame request, only looked at while idle
//   tx_data      : frame contents, captured on the accepting edge
//   TxD          : serial line, idles high
//   busy         : high from the cycle after acceptance until the frame ends
//   tx_complete  : one-cycle pulse after the last stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// each byte's data bits (11 bit periods per byte instead of 10).
module uart_frame_tx
    import comm_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic               TxD,
    output logic               busy,
    output logic               tx_complete
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [4:0] LAST_BYTE = 5'(FRAME_BYTES - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_frame_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    tx_state_t          state_r;
    logic [FRAME_W-1:0] shift_r;
    logic [4:0]         byte_idx_r;
    logic [2:0]         bit_idx_r;
    logic               txd_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               tick_s;
    logic [7:0]         cur_byte_s;

    // A frame is accepted only from IDLE, which includes the tx_complete cycle.
    assign accept_s   = (state_r == IDLE) && start;
    assign cur_byte_s = shift_r[7:0];

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .resetn (resetn),
        .clear  (accept_s),
        .tick   (tick_s)
    );

    // Frame state machine; the line value for the next bit is registered on
    // the boundary tick so TxD never glitches between equal bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            byte_idx_r <= 5'd0;
            bit_idx_r  <= 3'd0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    txd_r  <= 1'b1;
                    busy_r <= 1'b0;
                    if (start) begin
                        shift_r    <= tx_data;
                        byte_idx_r <= 5'd0;
                        bit_idx_r  <= 3'd0;
                        txd_r      <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        bit_idx_r <= 3'd0;
                        txd_r     <= cur_byte_s[0];
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_r   <= even_parity(cur_byte_s);
                            state_r <= PARITY;
`else
                            txd_r   <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            txd_r     <= cur_byte_s[bit_idx_r + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        txd_r   <= 1'b1;
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        if (byte_idx_r == LAST_BYTE) begin
                            txd_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            // Next byte moves into the low 8 bits of the shift register.
                            byte_idx_r <= byte_idx_r + 5'd1;
                            shift_r    <= {8'h00, shift_r[FRAME_W-1:8]};
                            txd_r      <= 1'b0;
                            state_r    <= START;
                        end
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign TxD         = txd_r;
    assign busy        = busy_r;
    assign tx_complete = done_r;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx at CLKS_PER_BIT = 10.
// A behavioural model predicts TxD/busy/tx_complete from the time elapsed
// since the accepted start edge; a line decoder rebuilds the sent bytes.
// Follows UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_frame_tx;

    localparam int C = 10;
`ifdef UART_TX_PARITY_EN
    localparam int BPB     = 11;
    localparam int LAT_LIT = 1871;
`else
    localparam int BPB     = 10;
    localparam int LAT_LIT = 1701;
`endif
    localparam int F = 17 * BPB * C;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [135:0] tx_data = '0;
    logic         TxD;
    logic         busy;
    logic         tx_complete;

    always #5 clk = ~clk;

    uart_frame_tx #(
        .CLK_HZ (50_000_000),
        .BAUD   (5_000_000)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .tx_data     (tx_data),
        .TxD         (TxD),
        .busy        (busy),
        .tx_complete (tx_complete)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [135:0] rand136();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[135:0];
    endfunction

    // ---------------- behavioural model ----------------
    int           cyc = 0;
    bit           m_active = 1'b0;
    int           m_n = 0;
    logic [135:0] m_data = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (start && (!m_active || (cyc + 1 - m_n) > F)) begin
                m_active <= 1'b1;
                m_n      <= cyc + 1;
                m_data   <= tx_data;
            end
        end
    end

    // {TxD, busy, tx_complete} d cycles after the accepting edge.
    function automatic logic [2:0] expect_out(input int d, input logic [135:0] data);
        int k, b, p;
        logic [7:0] by;
        logic txd;
        if (d >= 0 && d < F) begin
            k  = d / C;
            b  = k / BPB;
            p  = k % BPB;
            by = data[8*b +: 8];
            if (p == 0)                    txd = 1'b0;
            else if (p <= 8)               txd = by[p-1];
            else if (BPB == 11 && p == 9)  txd = ^by;
            else                           txd = 1'b1;
            return {txd, 1'b1, 1'b0};
        end else if (d == F) begin
            return 3'b101;
        end else begin
            return 3'b100;
        end
    endfunction

    always @(negedge clk) begin
        logic [2:0] e;
        if (resetn === 1'b1) begin
            e = m_active ? expect_out(cyc - m_n, m_data) : 3'b100;
            chk("cyc_txd",  {63'd0, TxD},         {63'd0, e[2]});
            chk("cyc_busy", {63'd0, busy},        {63'd0, e[1]});
            chk("cyc_tc",   {63'd0, tx_complete}, {63'd0, e[0]});
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] mon_q[$];
    bit         par_q[$];
    int         stop_err = 0;
    int         tc_cnt = 0;

    always @(negedge clk) begin
        if (resetn === 1'b1 && tx_complete === 1'b1) tc_cnt <= tc_cnt + 1;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && TxD === 1'b0) begin
                logic [7:0] by;
                repeat (C/2) @(negedge clk);
                if (TxD === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (C) @(negedge clk);
                        by[i] = TxD;
                    end
`ifdef UART_TX_PARITY_EN
                    repeat (C) @(negedge clk);
                    par_q.push_back(TxD);
`endif
                    repeat (C) @(negedge clk);
                    if (TxD !== 1'b1) stop_err++;
                    mon_q.push_back(by);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [135:0] d, output int acc);
        @(posedge clk);
        #1;
        start   = 1'b1;
        tx_data = d;
        @(posedge clk);
        #1;
        acc     = cyc;
        start   = 1'b0;
        tx_data = rand136();
    endtask

    task automatic wait_tc(input string nm, input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (tx_complete === 1'b1) begin
                e = cyc;
                break;
            end
        end
        if (e < 0) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_frame(input string nm, input int base, input logic [135:0] d);
        chk({nm, "_nbytes"}, 64'(mon_q.size() - base), 64'd17);
        for (int i = 0; i < 17; i++) begin
            if (base + i < mon_q.size())
                chk({nm, "_byte"}, {56'd0, mon_q[base + i]}, {56'd0, d[8*i +: 8]});
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int acc, e, base, tcb;
        logic [135:0] d, lit;

        // reset idle
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_txd",  {63'd0, TxD},         64'd1);
            chk("rst_busy", {63'd0, busy},        64'd0);
            chk("rst_tc",   {63'd0, tx_complete}, 64'd0);
        end
        resetn = 1'b1;
        tick(100);
        chk("idle_txd",  {63'd0, TxD},  64'd1);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // single frame with a known pattern
        lit  = 136'h11_0F0E0D0C0B0A09080706050403020100;
        base = mon_q.size();
        tcb  = tc_cnt;
        @(posedge clk);
        #1;
        start   = 1'b1;
        tx_data = lit;
        chk("pre_start_txd", {63'd0, TxD}, 64'd1);
        @(posedge clk);
        #1;
        acc     = cyc;
        start   = 1'b0;
        tx_data = rand136();
        chk("first_low_txd", {63'd0, TxD},  64'd0);
        chk("first_busy",    {63'd0, busy}, 64'd1);
        wait_tc("single", F + 20, e);
        chk("single_latency", 64'(e + 1 - acc), 64'(LAT_LIT));
        tick(20);
        chk("single_tc_count", 64'(tc_cnt - tcb), 64'd1);
        chk("single_nbytes", 64'(mon_q.size() - base), 64'd17);
        if (mon_q.size() >= base + 17) begin
            for (int i = 0; i < 16; i++)
                chk("single_lit_byte", {56'd0, mon_q[base + i]}, 64'(i));
            chk("single_last_byte", {56'd0, mon_q[base + 16]}, 64'h11);
        end

`ifdef UART_TX_PARITY_EN
        // parity bits for known bytes
        begin
            int pbase;
            d = rand136();
            d[7:0]  = 8'h07;
            d[15:8] = 8'h03;
            pbase = par_q.size();
            base  = mon_q.size();
            send(d, acc);
            wait_tc("parity", F + 20, e);
            tick(20);
            chk("parity_latency", 64'(e + 1 - acc), 64'd1871);
            check_frame("parity", base, d);
            if (par_q.size() >= pbase + 17) begin
                chk("parity_b0", {63'd0, par_q[pbase]},     64'd1);
                chk("parity_b1", {63'd0, par_q[pbase + 1]}, 64'd0);
                for (int i = 2; i < 17; i++)
                    chk("parity_bit", {63'd0, par_q[pbase + i]}, {63'd0, ^d[8*i +: 8]});
            end else begin
                chk("parity_count", 64'(par_q.size() - pbase), 64'd17);
            end
        end
`endif

        // start while busy is ignored
        d    = rand136();
        base = mon_q.size();
        tcb  = tc_cnt;
        send(d, acc);
        tick(499);
        start   = 1'b1;
        tx_data = ~d;
        tick(1);
        start   = 1'b0;
        wait_tc("busy_ign", F + 20, e);
        tick(20);
        check_frame("busy_ign", base, d);
        chk("busy_ign_tc_count", 64'(tc_cnt - tcb), 64'd1);

        // back-to-back frames
        d    = rand136();
        base = mon_q.size();
        tcb  = tc_cnt;
        send(d, acc);
        wait_tc("b2b_first", F + 20, e);
        start   = 1'b1;
        tx_data = {136{1'b1}};
        tick(1);
        acc   = cyc;
        start = 1'b0;
        chk("b2b_start_txd", {63'd0, TxD}, 64'd0);
        chk("b2b_gap", 64'(acc - e), 64'd1);
        wait_tc("b2b_second", F + 20, e);
        tick(20);
        chk("b2b_nbytes", 64'(mon_q.size() - base), 64'd34);
        if (mon_q.size() >= base + 34) begin
            for (int i = 0; i < 17; i++)
                chk("b2b_byte1", {56'd0, mon_q[base + i]}, {56'd0, d[8*i +: 8]});
            for (int i = 17; i < 34; i++)
                chk("b2b_byte2", {56'd0, mon_q[base + i]}, 64'hFF);
        end
        chk("b2b_tc_count", 64'(tc_cnt - tcb), 64'd2);

        // reset in the middle of a frame
        d = rand136();
        send(d, acc);
        tick(799);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_txd",  {63'd0, TxD},  64'd1);
        chk("async_busy", {63'd0, busy}, 64'd0);
        tick(3);
        resetn = 1'b1;
        tick(200);
        d    = rand136();
        base = mon_q.size();
        tcb  = tc_cnt;
        send(d, acc);
        wait_tc("post_rst", F + 20, e);
        tick(20);
        check_frame("post_rst", base, d);
        chk("post_rst_tc_count", 64'(tc_cnt - tcb), 64'd1);

        // random frames with random idle gaps and ignored start pulses
        for (int r = 0; r < 4; r++) begin
            d = rand136();
            tick($urandom_range(0, 40));
            base = mon_q.size();
            tcb  = tc_cnt;
            send(d, acc);
            tick($urandom_range(1, F - 2));
            start   = 1'b1;
            tx_data = rand136();
            tick(1);
            start = 1'b0;
            wait_tc("rand", F + 20, e);
            tick(20);
            check_frame("rand", base, d);
            chk("rand_tc_count", 64'(tc_cnt - tcb), 64'd1);
        end

        chk("stop_bits", 64'(stop_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serializes one 136-bit frame into 17 UART bytes on a single TxD line: 8 data bits, no parity, 1 stop bit (8N1). It is the transmit end of the coprocessor's serial link and the counterpart of the receive path that assembles `rx_data`. It takes the 136-bit `tx_data` word read from main memory and returns it to the host with the same framing and byte order the receive side expects.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate.
- `CLKS_PER_BIT`, default `CLK_HZ/BAUD` (derived, localparam): clocks per bit period; must be ≥ 2 (elaboration error otherwise).
- `clk` input 1: single system clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: request to transmit; sampled only when `busy`=0.
- `tx_data` input 136: frame to send; captured on the accepting edge.
- `TxD` output 1: serial line, idle high.
- `busy` output 1: high from the cycle after acceptance until the frame ends.
- `tx_complete` output 1: one-cycle pulse at end of frame.

## Operation
- Reset values: `TxD`=1, `busy`=0, `tx_complete`=0, state IDLE, all counters 0. Reset is asynchronous; asserting it mid-frame forces `TxD` high immediately and abandons the frame. No partial byte is finished.
- States:
  - IDLE, with `busy`=0.
  - START, driving `TxD`=0.
  - DATA, driving bit `bit_idx` of the current byte, LSB first.
  - PARITY, only when the parity option is compiled in.
  - STOP, driving `TxD`=1.
- Transitions:
  - IDLE→START on `start`=1. `tx_data` is latched into a shift register; `byte_idx` and `bit_idx` are cleared.
  - START→DATA after one bit period.
  - DATA stays for 8 bit periods (`bit_idx` 0..7), then goes to PARITY or STOP.
  - STOP→START if `byte_idx`<16, incrementing `byte_idx`.
  - STOP→IDLE if `byte_idx`=16, pulsing `tx_complete`.
- Byte order: byte 0 = `tx_data[7:0]` first, byte 16 = `tx_data[135:128]` last.
- Each byte is taken by shifting the latched register right 8 bits after its stop bit. Changes on the `tx_data` port after acceptance have no effect.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the same cycle that `tx_complete` is high is accepted: back-to-back frames with no extra idle bit.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps; a bit boundary occurs at the wrap. Widths:
  - baud counter is `$clog2(CLKS_PER_BIT)` bits;
  - `bit_idx` is 3 bits;
  - `byte_idx` is 5 bits and never exceeds 16.

## Timing
- Edge N samples `start`=1 in IDLE. From N+1: `busy`=1 and `TxD`=0 (start bit). The output is registered, so latency is 1 cycle.
- Every bit holds `TxD` for exactly `CLKS_PER_BIT` cycles, with no glitches between bits of equal value.
- Frame length F = 17 × 10 × `CLKS_PER_BIT` cycles, or 17 × 11 × `CLKS_PER_BIT` with parity.
- The last stop bit occupies cycles N+F-`CLKS_PER_BIT`+1 .. N+F.
- Cycle N+F+1: `tx_complete`=1, `busy`=0 and `TxD`=1, all for one cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - a PARITY state inserts one even-parity bit (XOR of the 8 data bits) between DATA and STOP;
  - each byte is 11 bit periods.
- Not defined: 8N1 as described, and the PARITY state does not exist.
- The receive path must be built with the matching setting.

## Structure
- Shared package `comm_pkg`:
  - `FRAME_W`=136 and `FRAME_BYTES`=17;
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - a `clks_per_bit(CLK_HZ, BAUD)` function reused by the receiver.
- One natural sub-module, `baud_tick`: the counter plus a one-cycle `tick` at each bit boundary, restarted on frame acceptance.
- The frame FSM, shift register and byte/bit counters stay in `uart_frame_tx`.

## Test plan
All scenarios use `CLK_HZ`=50_000_000 and `BAUD`=5_000_000, so `CLKS_PER_BIT`=10.
- Reset idle: hold `resetn`=0 for 5 cycles, then release with `start`=0 for 100 cycles → `TxD`=1, `busy`=0, `tx_complete`=0 throughout.
- Single frame:
  - stimulus: `tx_data`=136'h11_0F0E0D0C0B0A09080706050403020100, one-cycle `start`;
  - line monitor decodes bytes 00,01,…,0F,11 in order;
  - `TxD` first goes low 1 cycle after `start`;
  - `tx_complete` pulses exactly once, 1701 cycles after the `start` edge.
- Start while busy: pulse `start` at cycle 500 of a frame with a different `tx_data` → ignored; the decoded frame is unchanged and only one `tx_complete` occurs.
- Back-to-back: reassert `start` on the `tx_complete` cycle with `tx_data`=all-ones → the second frame's start bit follows the previous stop bit immediately; 34 bytes are decoded, the last 17 being FF.
- Reset mid-frame: assert `resetn`=0 at cycle 800 → `TxD`=1 and `busy`=0 in that same cycle (asynchronously); after release, a new `start` sends a complete, correct frame.
- Parity build (`UART_TX_PARITY_EN` defined), byte 0 = 8'h07 → parity bit 1; byte 1 = 8'h03 → parity bit 0; frame length 1870 cycles.
